// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Round-robin arbiter that shares one single-port synchronous SRAM among
//   NREQ requesters. Each accepted command flows through three register
//   stages (C: drive SRAM, D: wait for read data, R: return response), so
//   one command per cycle is sustained with up to three in flight.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_req_valid/ready   per-requester command handshake (ready is one-hot)
//   i_req_write         1=write, 0=read
//   i_req_addr          flattened byte addresses, ABITS per requester
//   i_req_wdata         flattened write data, DBITS per requester
//   i_req_wstrb         flattened byte strobes, DBITS/8 per requester
//   o_resp_valid        one-hot response strobe, three cycles after acceptance
//   o_resp_rdata        response data (zero for writes and idle cycles)
//   o_mem_*             SRAM command (word address), zeroed when o_mem_cs=0
//   i_mem_rdata         SRAM read data, valid the cycle after o_mem_cs
module sram_arbiter #(
   parameter int NREQ        = 4,
   parameter int ABITS       = 18,
   parameter int DBITS       = 64,
   parameter int async_reset = 1
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [NREQ-1:0]                      i_req_valid,
   output logic [NREQ-1:0]                      o_req_ready,
   input  logic [NREQ-1:0]                      i_req_write,
   input  logic [NREQ*ABITS-1:0]                i_req_addr,
   input  logic [NREQ*DBITS-1:0]                i_req_wdata,
   input  logic [NREQ*DBITS/8-1:0]              i_req_wstrb,
   output logic [NREQ-1:0]                      o_resp_valid,
   output logic [DBITS-1:0]                     o_resp_rdata,
   output logic                                 o_mem_cs,
   output logic                                 o_mem_we,
   output logic [ABITS-$clog2(DBITS/8)-1:0]     o_mem_addr,
   output logic [DBITS-1:0]                     o_mem_wdata,
   output logic [DBITS/8-1:0]                   o_mem_wstrb,
   input  logic [DBITS-1:0]                     i_mem_rdata
);

   localparam int SBITS = DBITS / 8;
   localparam int OFS   = $clog2(SBITS);
   localparam int MBITS = ABITS - OFS;
   localparam int IDW   = $clog2(NREQ);

   // ---------------------------------------------------------------- arbiter
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   win_id;
   logic [IDW-1:0]   cand;
   logic             found;
   logic             fire;

   // Search starts one past the last winner, so the last winner has lowest
   // priority; a lone requester wraps around to itself and wins every cycle.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      cand   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = IDW'((int'(rr_ptr) + i) % NREQ);
         if (!found && i_req_valid[cand]) begin
            found  = 1'b1;
            win_id = cand;
         end
      end
   end

   assign fire = found & ~i_rst;

   always_comb begin
      o_req_ready = '0;
      if (fire) o_req_ready[win_id] = 1'b1;
   end

   logic [ABITS-1:0] win_addr;
   logic [DBITS-1:0] win_wdata;
   logic [SBITS-1:0] win_wstrb;

   assign win_addr  = i_req_addr [int'(win_id)*ABITS +: ABITS];
   assign win_wdata = i_req_wdata[int'(win_id)*DBITS +: DBITS];
   assign win_wstrb = i_req_wstrb[int'(win_id)*SBITS +: SBITS];

   // Byte-offset bits never reach the word-addressed SRAM.
   logic unused_bits;
   assign unused_bits = ^{win_addr[OFS-1:0], async_reset[0]};

   // --------------------------------------------------------------- pipeline
   // vld_pipe[1]=C (SRAM access), [2]=D (read data returning), [3]=R (resp)
   logic [3:1]       vld_pipe;
   logic [IDW-1:0]   c_id, d_id, r_id;
   logic             c_we, d_we;
   logic [MBITS-1:0] c_addr;
   logic [DBITS-1:0] c_wdata;
   logic [SBITS-1:0] c_wstrb;
   logic [DBITS-1:0] r_rdata;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rr_ptr   <= IDW'(NREQ - 1);
         vld_pipe <= '0;
         c_id     <= '0;
         c_we     <= 1'b0;
         c_addr   <= '0;
         c_wdata  <= '0;
         c_wstrb  <= '0;
         d_id     <= '0;
         d_we     <= 1'b0;
         r_id     <= '0;
         r_rdata  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[2:1], fire};
         if (fire) begin
            rr_ptr  <= win_id;
            c_id    <= win_id;
            c_we    <= i_req_write[win_id];
            c_addr  <= win_addr[ABITS-1:OFS];
            c_wdata <= win_wdata;
            c_wstrb <= win_wstrb;
         end
         d_id <= c_id;
         d_we <= c_we;
         r_id <= d_id;
         // Only reads return data; writes and bubbles load zero so the
         // response bus is quiet whenever no read response is presented.
         r_rdata <= (vld_pipe[2] && !d_we) ? i_mem_rdata : '0;
      end
   end

   assign o_mem_cs    = vld_pipe[1];
   assign o_mem_we    = vld_pipe[1] & c_we;
   assign o_mem_addr  = vld_pipe[1] ? c_addr  : '0;
   assign o_mem_wdata = vld_pipe[1] ? c_wdata : '0;
   assign o_mem_wstrb = vld_pipe[1] ? c_wstrb : '0;

   always_comb begin
      o_resp_valid = '0;
      if (vld_pipe[3]) o_resp_valid[r_id] = 1'b1;
   end

   assign o_resp_rdata = r_rdata;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter ABITS, default CFG_SRAM_LOG2_SIZE (18): byte-address width.
REQ-003 Parameter DBITS, default 64: data width; strobe width is DBITS/8.
REQ-004 Parameter async_reset, default CFG_ASYNC_RESET: reset style selector; this block's reset is asynchronous and active-high in all builds.
REQ-005 i_clk  in  1  single clock, rising edge.
REQ-006 i_rst  in  1  reset, asynchronous, active-high.
REQ-007 i_req_valid  in  NREQ  per-requester command valid.
REQ-008 o_req_ready  out  NREQ  per-requester command accepted.
REQ-009 i_req_write  in  NREQ  1=write, 0=read.
REQ-010 i_req_addr  in  NREQ*ABITS  flattened byte addresses; requester k occupies slice k.
REQ-011 i_req_wdata  in  NREQ*DBITS  flattened write data.
REQ-012 i_req_wstrb  in  NREQ*DBITS/8  flattened byte strobes.
REQ-013 o_resp_valid  out  NREQ  one-hot response strobe.
REQ-014 o_resp_rdata  out  DBITS  shared response data.
REQ-015 o_mem_cs  out  1  SRAM select.
REQ-016 o_mem_we  out  1  SRAM write enable.
REQ-017 o_mem_addr  out  ABITS-log2(DBITS/8)  SRAM word address.
REQ-018 o_mem_wdata  out  DBITS  SRAM write data.
REQ-019 o_mem_wstrb  out  DBITS/8  SRAM byte enables.
REQ-020 i_mem_rdata  in  DBITS  SRAM read data, valid the cycle after o_mem_cs.

Function
REQ-021 Arbitration shall be round-robin: search starts at rr_ptr+1 mod NREQ, first asserted i_req_valid wins.
REQ-022 o_req_ready shall be one-hot on the winner only, combinational, and all-zero when no valid.
REQ-023 Handshake shall complete in cycle T when i_req_valid[k] & o_req_ready[k]; rr_ptr shall update to k at the T edge.
REQ-024 A requester shall hold valid and payload stable until ready; the arbiter shall never retract a grant because another requester asserts.
REQ-025 Pipeline: stage C (cycle T+1) drives o_mem_cs=1 and registered command; stage D (T+2) captures i_mem_rdata; stage R (T+3) drives o_resp_valid[k]=1.
REQ-026 Throughput shall be one command per cycle; three commands shall be in flight simultaneously with no stall.
REQ-027 o_mem_addr shall be i_req_addr[ABITS-1:log2(DBITS/8)] of the winner; low bits dropped.
REQ-028 o_mem_we, o_mem_wdata and o_mem_wstrb shall be zero when o_mem_cs=0.
REQ-029 Writes shall also return o_resp_valid at T+3 with o_resp_rdata=0.
REQ-030 o_resp_rdata shall be 0 in cycles with no o_resp_valid.
REQ-031 Responses shall be issued in acceptance order; the requester id travels with each pipeline stage.
REQ-032 No response backpressure: requesters shall sink o_resp_valid in the cycle asserted.
REQ-033 Read after write to the same address, back-to-back, shall return the new data (SRAM is write-first; arbiter preserves order).
REQ-034 A single requester holding valid continuously shall be granted every cycle.

Reset
REQ-035 On i_rst=1: rr_ptr=NREQ-1 (requester 0 has first priority); all stage valids cleared; o_mem_cs=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_wstrb=0, o_resp_valid=0, o_resp_rdata=0.
REQ-036 Reset asserted mid-operation shall discard all in-flight commands with no response; o_req_ready shall be 0 while i_rst=1.
REQ-037 First grant shall be possible in the first clock edge after i_rst deasserts.

Verification
REQ-038 After reset, all 4 valid in cycle 0 and held -> grants 0,1,2,3,0 in consecutive cycles; o_mem_cs continuously 1 from cycle 1.
REQ-039 Req 2 write addr 0x108, wdata 0xA5A5_0000_1234_5678, wstrb 0xFF; next cycle read 0x108 -> o_mem_addr=0x21 twice; read resp to req 2 at T+4 with data 0xA5A5_0000_1234_5678.
REQ-040 rr_ptr=1, valids on req 0 and 3 -> req 3 granted first, then req 0.
REQ-041 Read issued at T, i_rst pulsed at T+2 -> no o_resp_valid at T+3; after release, req 0 wins first.
REQ-042 Random 10k-cycle traffic, 4 requesters vs. SRAM reference model -> data match, one response per accepted command, in-order, no grant wait over 3 cycles.
